// File: rtl/spi_dc_pkg.sv
// Shared types and helpers for the parametrised daisy-chain SPI slave.
package spi_dc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    SEND
  } spi_dc_state_t;

  // Map transfer position k to the word bit it carries.
  function automatic int unsigned bit_pos(input int unsigned k,
                                          input int unsigned data_w,
                                          input bit          lsb_first);
    return lsb_first ? k : (data_w - 1 - k);
  endfunction

endpackage

// File: rtl/spi_daisy_slave_param.sv
// Daisy-chain SPI slave clocked by sclk (negedge): receives one DATA_W word
// on sdi, then forwards either that word or tx_data on sdo.
module spi_daisy_slave_param
  import spi_dc_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          LSB_FIRST = 1'b1,
  parameter bit          TX_SRC    = 1'b0
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              newd,
  input  logic              sdi,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              rx_ack,
  output logic              sdo,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              overrun,
  output logic              done_receiving,
  output logic              done_sending,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned       CW      = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]     LAST_RX = CW'(DATA_W - 1);
  localparam logic [CW-1:0]     LAST_TX = CW'(DATA_W);
  localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);

  spi_dc_state_t     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] txw_q, txw_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              sdo_q, sdo_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;
  logic              done_rx_q, done_rx_d;
  logic              done_tx_q, done_tx_d;
  logic              ferr_q, ferr_d;

  int unsigned       pos_k, pos_0;
  logic [DATA_W-1:0] word_in, tx_next, tx_first, tx_cur;
  logic              complete;

  // Next-state, datapath and rx handshake for the coming sclk negedge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    txw_d     = txw_q;
    rx_data_d = rx_data_q;
    sdo_d     = sdo_q;
    done_rx_d = 1'b0;
    done_tx_d = 1'b0;
    ferr_d    = 1'b0;
    complete  = 1'b0;

    pos_k    = bit_pos(32'(cnt_q), DATA_W, LSB_FIRST);
    pos_0    = bit_pos(0, DATA_W, LSB_FIRST);
    // Word as it stands after capturing sdi at the current position.
    word_in  = (shift_q & ~(ONE << pos_k)) | (DATA_W'(sdi) << pos_k);
    tx_next  = TX_SRC ? tx_data : word_in;
    tx_first = tx_next >> pos_0;
    tx_cur   = txw_q >> pos_k;

    unique case (state_q)
      IDLE: begin
        sdo_d = 1'b0;
        cnt_d = '0;
        if (!cs && newd) begin
          shift_d = DATA_W'(sdi) << pos_0;
          cnt_d   = CW'(1);
          state_d = RECEIVE;
        end
      end
      RECEIVE: begin
        if (cs) begin
          state_d = IDLE;
          cnt_d   = '0;
          sdo_d   = 1'b0;
          ferr_d  = 1'b1;
        end else if (cnt_q == LAST_RX) begin
          complete  = 1'b1;
          shift_d   = word_in;
          rx_data_d = word_in;
          txw_d     = tx_next;
          sdo_d     = tx_first[0];
          cnt_d     = CW'(1);
          done_rx_d = 1'b1;
          state_d   = SEND;
        end else begin
          shift_d = word_in;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      SEND: begin
        if (cs) begin
          state_d = IDLE;
          cnt_d   = '0;
          sdo_d   = 1'b0;
          ferr_d  = 1'b1;
        end else if (cnt_q == LAST_TX) begin
          sdo_d     = 1'b0;
          done_tx_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          sdo_d = tx_cur[0];
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sdo_d   = 1'b0;
      end
    endcase

    // Completion wins over ack for rx_valid; ack always clears overrun.
    rx_valid_d = complete ? 1'b1 : (rx_ack ? 1'b0 : rx_valid_q);
    overrun_d  = rx_ack ? 1'b0 : ((complete && rx_valid_q) ? 1'b1 : overrun_q);
  end

  // State and output registers, asynchronously cleared.
  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      txw_q      <= '0;
      rx_data_q  <= '0;
      sdo_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      done_rx_q  <= 1'b0;
      done_tx_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      txw_q      <= txw_d;
      rx_data_q  <= rx_data_d;
      sdo_q      <= sdo_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      done_rx_q  <= done_rx_d;
      done_tx_q  <= done_tx_d;
      ferr_q     <= ferr_d;
    end
  end

  assign sdo            = sdo_q;
  assign rx_data        = rx_data_q;
  assign rx_valid       = rx_valid_q;
  assign overrun        = overrun_q;
  assign done_receiving = done_rx_q;
  assign done_sending   = done_tx_q;
  assign frame_err      = ferr_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_spi_daisy_slave_param.sv
// Bench for spi_daisy_slave_param: two instances (LSB-first echo and
// MSB-first tx_data) checked against a frame-level reference model.
module tb_spi_daisy_slave_param;

  logic       sclk = 1'b0;
  logic       rst_n;
  logic       cs[2], newd[2], sdi[2], rx_ack[2];
  logic [7:0] tx_data[2];
  logic       sdo[2], rx_valid[2], overrun[2], done_rx[2], done_tx[2];
  logic       frame_err[2], busy[2];
  logic [7:0] rx_data[2];

  // Reference model of the held-word handshake.
  logic [7:0] m_rx[2];
  logic       m_valid[2], m_over[2];

  int passed = 0;
  int total  = 0;

  always #5 sclk = ~sclk;

  spi_daisy_slave_param #(.DATA_W(8), .LSB_FIRST(1'b1), .TX_SRC(1'b0)) u_a (
    .sclk(sclk), .rst_n(rst_n), .cs(cs[0]), .newd(newd[0]), .sdi(sdi[0]),
    .tx_data(tx_data[0]), .rx_ack(rx_ack[0]), .sdo(sdo[0]), .rx_data(rx_data[0]),
    .rx_valid(rx_valid[0]), .overrun(overrun[0]), .done_receiving(done_rx[0]),
    .done_sending(done_tx[0]), .frame_err(frame_err[0]), .busy(busy[0]));

  spi_daisy_slave_param #(.DATA_W(8), .LSB_FIRST(1'b0), .TX_SRC(1'b1)) u_b (
    .sclk(sclk), .rst_n(rst_n), .cs(cs[1]), .newd(newd[1]), .sdi(sdi[1]),
    .tx_data(tx_data[1]), .rx_ack(rx_ack[1]), .sdo(sdo[1]), .rx_data(rx_data[1]),
    .rx_valid(rx_valid[1]), .overrun(overrun[1]), .done_receiving(done_rx[1]),
    .done_sending(done_tx[1]), .frame_err(frame_err[1]), .busy(busy[1]));

  function automatic logic bit_at(input logic [7:0] w, input int p);
    logic [7:0] t;
    t = w >> p;
    return t[0];
  endfunction

  // Instance 0 sends LSB first, instance 1 MSB first.
  function automatic int pos_of(input int d, input int k);
    return (d == 0) ? k : 7 - k;
  endfunction

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      cs[d] = 1'b1; newd[d] = 1'b0; sdi[d] = 1'b0; rx_ack[d] = 1'b0;
    end
  endtask

  task automatic edge_step();
    @(negedge sclk);
    #1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rx[d] = 8'h00; m_valid[d] = 1'b0; m_over[d] = 1'b0;
    end
  endtask

  // One frame on instance d; abort_at in 1..15 raises cs on that edge index, 16 = no abort.
  task automatic run_frame(input int d, input logic [7:0] word, input logic ack_end,
                           input int abort_at);
    logic [7:0] txw;
    txw = (d == 0) ? word : tx_data[d];
    for (int e = 0; e < 16; e++) begin
      idle_all();
      if (e == abort_at) begin
        edge_step();
        total++; if (frame_err[d] !== 1'b1) $display("FAIL abort_ferr d%0d e%0d got %b exp 1", d, e, frame_err[d]); else passed++;
        total++; if (busy[d] !== 1'b0) $display("FAIL abort_busy d%0d got %b exp 0", d, busy[d]); else passed++;
        total++; if (sdo[d] !== 1'b0) $display("FAIL abort_sdo d%0d got %b exp 0", d, sdo[d]); else passed++;
        total++; if ({done_rx[d], done_tx[d]} !== 2'b00) $display("FAIL abort_done d%0d got %b%b exp 00", d, done_rx[d], done_tx[d]); else passed++;
        total++; if (rx_data[d] !== m_rx[d]) $display("FAIL abort_rxdata d%0d got %h exp %h", d, rx_data[d], m_rx[d]); else passed++;
        total++; if (rx_valid[d] !== m_valid[d]) $display("FAIL abort_valid d%0d got %b exp %b", d, rx_valid[d], m_valid[d]); else passed++;
        total++; if (overrun[d] !== m_over[d]) $display("FAIL abort_overrun d%0d got %b exp %b", d, overrun[d], m_over[d]); else passed++;
        edge_step();
        total++; if (frame_err[d] !== 1'b0) $display("FAIL ferr_pulse d%0d got %b exp 0", d, frame_err[d]); else passed++;
        return;
      end
      cs[d]   = 1'b0;
      newd[d] = (e == 0) ? 1'b1 : 1'($urandom);
      sdi[d]  = (e < 8) ? bit_at(word, pos_of(d, e)) : 1'($urandom);
      if (e == 7) rx_ack[d] = ack_end;
      edge_step();
      if (e < 7) begin
        total++; if (done_rx[d] !== 1'b0) $display("FAIL early_done_rx d%0d e%0d got %b exp 0", d, e, done_rx[d]); else passed++;
        total++; if (busy[d] !== 1'b1) $display("FAIL rx_busy d%0d e%0d got %b exp 1", d, e, busy[d]); else passed++;
      end else if (e == 7) begin
        if (ack_end) m_over[d] = 1'b0;
        else if (m_valid[d]) m_over[d] = 1'b1;
        m_valid[d] = 1'b1;
        m_rx[d]    = word;
        total++; if (done_rx[d] !== 1'b1) $display("FAIL done_rx d%0d got %b exp 1", d, done_rx[d]); else passed++;
        total++; if (rx_data[d] !== m_rx[d]) $display("FAIL rx_data d%0d got %h exp %h", d, rx_data[d], m_rx[d]); else passed++;
        total++; if (rx_valid[d] !== m_valid[d]) $display("FAIL rx_valid d%0d got %b exp %b", d, rx_valid[d], m_valid[d]); else passed++;
        total++; if (overrun[d] !== m_over[d]) $display("FAIL overrun d%0d got %b exp %b", d, overrun[d], m_over[d]); else passed++;
        total++; if (sdo[d] !== bit_at(txw, pos_of(d, 0))) $display("FAIL sdo d%0d k0 got %b exp %b", d, sdo[d], bit_at(txw, pos_of(d, 0))); else passed++;
      end else if (e < 15) begin
        total++; if (sdo[d] !== bit_at(txw, pos_of(d, e - 7))) $display("FAIL sdo d%0d k%0d got %b exp %b", d, e - 7, sdo[d], bit_at(txw, pos_of(d, e - 7))); else passed++;
        total++; if (done_tx[d] !== 1'b0) $display("FAIL early_done_tx d%0d e%0d got %b exp 0", d, e, done_tx[d]); else passed++;
      end else begin
        total++; if (done_tx[d] !== 1'b1) $display("FAIL done_tx d%0d got %b exp 1", d, done_tx[d]); else passed++;
        total++; if (sdo[d] !== 1'b0) $display("FAIL end_sdo d%0d got %b exp 0", d, sdo[d]); else passed++;
        total++; if (busy[d] !== 1'b0) $display("FAIL end_busy d%0d got %b exp 0", d, busy[d]); else passed++;
      end
    end
    idle_all();
  endtask

  task automatic apply_ack(input int d);
    idle_all();
    rx_ack[d] = 1'b1;
    edge_step();
    m_valid[d] = 1'b0;
    m_over[d]  = 1'b0;
    total++; if (rx_valid[d] !== 1'b0) $display("FAIL ack_valid d%0d got %b exp 0", d, rx_valid[d]); else passed++;
    total++; if (overrun[d] !== 1'b0) $display("FAIL ack_overrun d%0d got %b exp 0", d, overrun[d]); else passed++;
    idle_all();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    tx_data[0] = 8'h00; tx_data[1] = 8'h00;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      total++; if ({sdo[d], rx_valid[d], overrun[d], done_rx[d], done_tx[d], frame_err[d], busy[d]} !== 7'b0)
        $display("FAIL reset_flags d%0d got %b exp 0000000", d, {sdo[d], rx_valid[d], overrun[d], done_rx[d], done_tx[d], frame_err[d], busy[d]}); else passed++;
      total++; if (rx_data[d] !== 8'h00) $display("FAIL reset_rxdata d%0d got %h exp 00", d, rx_data[d]); else passed++;
    end
    #3 rst_n = 1'b1;
    edge_step();
  endtask

  task automatic test_lsb_echo();
    run_frame(0, 8'hA5, 1'b0, 16);
  endtask

  task automatic test_msb_txdata();
    tx_data[1] = 8'h3C;
    run_frame(1, 8'h81, 1'b0, 16);
  endtask

  task automatic test_back_to_back();
    apply_ack(0);
    run_frame(0, 8'h11, 1'b0, 16);
    run_frame(0, 8'h22, 1'b0, 16);
    apply_ack(0);
  endtask

  task automatic test_ack_coincident();
    run_frame(0, 8'h33, 1'b0, 16);
    run_frame(0, 8'h44, 1'b1, 16);
  endtask

  task automatic test_abort();
    run_frame(0, 8'h5A, 1'b0, 16);
    run_frame(0, 8'hC3, 1'b0, 4);
    run_frame(0, 8'h96, 1'b0, 16);
    tx_data[1] = 8'hE7;
    run_frame(1, 8'h18, 1'b0, 11);
    run_frame(1, 8'h7E, 1'b0, 16);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int d;
      int ab;
      d  = int'($urandom_range(0, 1));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
      tx_data[d] = 8'($urandom);
      run_frame(d, 8'($urandom), ($urandom_range(0, 2) == 0), ab);
      if ($urandom_range(0, 2) == 0) apply_ack(d);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        idle_all();
        newd[0] = 1'($urandom); newd[1] = 1'($urandom);
        edge_step();
        total++; if ({busy[0], busy[1]} !== 2'b00) $display("FAIL idle_busy got %b%b exp 00", busy[0], busy[1]); else passed++;
      end
      idle_all();
    end
  endtask

  task automatic test_reset_mid_send();
    for (int e = 0; e < 11; e++) begin
      idle_all();
      cs[0] = 1'b0; newd[0] = 1'b1; sdi[0] = (e < 8) ? 1'b1 : 1'b0;
      edge_step();
    end
    total++; if (sdo[0] !== 1'b1) $display("FAIL pre_reset_sdo got %b exp 1", sdo[0]); else passed++;
    total++; if (busy[0] !== 1'b1) $display("FAIL pre_reset_busy got %b exp 1", busy[0]); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (sdo[0] !== 1'b0) $display("FAIL async_sdo got %b exp 0", sdo[0]); else passed++;
    total++; if (busy[0] !== 1'b0) $display("FAIL async_busy got %b exp 0", busy[0]); else passed++;
    total++; if (rx_valid[0] !== 1'b0) $display("FAIL async_valid got %b exp 0", rx_valid[0]); else passed++;
    total++; if (rx_data[0] !== 8'h00) $display("FAIL async_rxdata got %h exp 00", rx_data[0]); else passed++;
    total++; if (overrun[0] !== 1'b0) $display("FAIL async_overrun got %b exp 0", overrun[0]); else passed++;
    model_reset();
    idle_all();
    #3 rst_n = 1'b1;
    edge_step();
    run_frame(0, 8'h6B, 1'b0, 16);
  endtask

  initial begin
    test_reset();
    test_lsb_echo();
    test_msb_txdata();
    test_back_to_back();
    test_ack_coincident();
    test_abort();
    test_random();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
